// File: rtl/ppu_out_wr_pkg.sv
// Types and constants shared by ppu_out_wr, its FIFO and anything that needs
// the result-vector width.
`include "incl.vh"

package ppu_out_wr_pkg;

  // One result vector leaving the PPU array: S*R bytes.
  localparam int DATA_W = `S * `R * 8;

  typedef enum logic [1:0] {
    ST_IDLE = `PPU_OUT_WR_IDLE,
    ST_RUN  = `PPU_OUT_WR_RUN,
    ST_DONE = `PPU_OUT_WR_DONE
  } state_t;

endpackage

// File: rtl/incl.vh
// Shared build-wide defines for the PPU array: lane geometry (S x R bytes per
// result vector) and the ppu_out_wr state encodings.
`ifndef PPU_OUT_WR_INCL_VH
`define PPU_OUT_WR_INCL_VH

`define S 4
`define R 4

`define PPU_OUT_WR_IDLE 2'd0
`define PPU_OUT_WR_RUN  2'd1
`define PPU_OUT_WR_DONE 2'd2

`endif

// File: rtl/ppu_out_fifo.sv
// Synchronous first-word-fall-through FIFO. dout always shows the head entry
// while the FIFO is non-empty. A push on a full FIFO is accepted only when a
// pop happens in the same cycle.
module ppu_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; both pointers clear on reset, which discards the contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; no reset needed since empty entries are never presented.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ppu_out_wr.sv
// PPU array back end: buffers result vectors in a FWFT FIFO and writes them
// to the output feature-map buffer as a rows x row_len block starting at a
// programmed base address, with a programmable stride between row starts.
//
// Optional build macro PPU_OUT_WR_PERF_EN adds the stall_cnt and idle_cnt
// performance counters.
//
// Handshake: a write transfers on a cycle where wr_en && wr_rdy; while wr_en
// is high and wr_rdy is low, wr_addr and wr_data hold their values and the
// FIFO is not popped. in_vld has no back-pressure: the PPU pipeline cannot
// stall, so in_afull warns upstream issue logic early and ovf records drops.
module ppu_out_wr
  import ppu_out_wr_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 8,
  parameter int ADDR_WIDTH   = 21,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  row_len,
  input  logic [CNT_WIDTH-1:0]  n_rows,
  input  logic                  in_vld,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_afull,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [1:0]            state_dbg
`ifdef PPU_OUT_WR_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           idle_cnt
`endif
);

  localparam int CW = $clog2(DEPTH);

  state_t                state;
  state_t                state_nx;

  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [CNT_WIDTH-1:0]  row_len_q;
  logic [CNT_WIDTH-1:0]  n_rows_q;
  logic [CNT_WIDTH-1:0]  row;
  logic [CNT_WIDTH-1:0]  col;

  logic                  f_push;
  logic                  f_pop;
  logic                  f_empty;
  logic                  f_full;
  logic [CW:0]           f_count;
  logic [CW:0]           count_nx;
  logic [DATA_W-1:0]     f_dout;

  logic                  accept;
  logic                  last_col;
  logic                  last_row;
  logic                  launch;

  // A start is only honoured from IDLE; in RUN and DONE it is ignored.
  assign launch   = (state == ST_IDLE) && start;
  assign accept   = wr_en && wr_rdy;
  assign last_col = (col == row_len_q - 1'b1);
  assign last_row = (row == n_rows_q - 1'b1);

  // Pushes happen in every state; a full FIFO still takes a vector when the
  // head leaves in the same cycle.
  assign f_pop    = accept;
  assign f_push   = in_vld && (!f_full || f_pop);
  assign count_nx = f_count + (CW+1)'(f_push) - (CW+1)'(f_pop);

  ppu_out_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .pop   (f_pop),
    .din   (in_data),
    .dout  (f_dout),
    .empty (f_empty),
    .full  (f_full),
    .count (f_count)
  );

  // Write port: FIFO head falls straight through while running.
  assign wr_en     = (state == ST_RUN) && !f_empty;
  assign wr_data   = wr_en ? f_dout : '0;
  assign wr_addr   = wr_addr_q;
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: RUN ends on the accepted write of the final vector.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (accept && last_col && last_row) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Block walker: latch operands on start, then step column/row per write.
  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q  <= '0;
      row_base  <= '0;
      wr_addr_q <= '0;
      row_len_q <= '0;
      n_rows_q  <= '0;
      row       <= '0;
      col       <= '0;
    end else if (launch) begin
      stride_q  <= stride;
      row_base  <= base;
      wr_addr_q <= base;
      row_len_q <= row_len;
      n_rows_q  <= n_rows;
      row       <= '0;
      col       <= '0;
    end else if (accept) begin
      if (!last_col) begin
        col       <= col + 1'b1;
        wr_addr_q <= wr_addr_q + 1'b1;
      end else begin
        col       <= '0;
        row       <= row + 1'b1;
        row_base  <= row_base + stride_q;
        wr_addr_q <= row_base + stride_q;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as start still records.
  always_ff @(posedge clk) begin
    if (rst)                            ovf <= 1'b0;
    else if (in_vld && f_full && !f_pop) ovf <= 1'b1;
    else if (launch)                    ovf <= 1'b0;
  end

  // Almost-full from the occupancy after this cycle's push/pop.
  always_ff @(posedge clk) begin
    if (rst) in_afull <= 1'b0;
    else     in_afull <= (int'(DEPTH) - int'(count_nx)) <= AFULL_MARGIN;
  end

`ifdef PPU_OUT_WR_PERF_EN
  // Saturating RUN-time counters: back-pressure stalls and starved cycles.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      stall_cnt <= '0;
      idle_cnt  <= '0;
    end else if (state == ST_RUN) begin
      if (wr_en && !wr_rdy && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (f_empty && (idle_cnt != 32'hFFFF_FFFF))
        idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ppu_out_wr.sv
// Bench for ppu_out_wr: directed block scenarios plus randomized blocks.
// The driver pushes expected addresses/data into queues; a negedge monitor
// pops and compares every accepted write and the done pulse.
module tb_ppu_out_wr;
  import ppu_out_wr_pkg::*;

  localparam int DEPTH        = 16;
  localparam int AFULL_MARGIN = 8;
  localparam int ADDR_W       = 21;
  localparam int CNT_W        = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] stride;
  logic [CNT_W-1:0]  row_len;
  logic [CNT_W-1:0]  n_rows;
  logic              in_vld;
  logic [DATA_W-1:0] in_data;
  logic              in_afull;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_rdy;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [1:0]        state_dbg;
`ifdef PPU_OUT_WR_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       idle_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                done_exp = 0;

  ppu_out_wr #(
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (AFULL_MARGIN),
    .ADDR_WIDTH   (ADDR_W),
    .CNT_WIDTH    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .stride    (stride),
    .row_len   (row_len),
    .n_rows    (n_rows),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .in_afull  (in_afull),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .state_dbg (state_dbg)
`ifdef PPU_OUT_WR_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .idle_cnt  (idle_cnt)
`endif
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_vec();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      done_exp = 0;
    end else begin
      if (done_exp) begin
        check("done_pulse", 64'(done), 64'd1);
        done_exp = 0;
      end else if (done) begin
        check("done_spurious", 64'(done), 64'd0);
      end
      if (wr_en && wr_rdy) begin
        n_acc++;
        if (addr_q.size() == 0 || exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0h with no write pending", wr_addr);
        end else begin
          check("wr_addr", 64'(wr_addr), 64'(addr_q.pop_front()));
          check_data("wr_data", wr_data, exp_q.pop_front());
          if (addr_q.size() == 0) done_exp = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference FIFO model: a vector is kept if there is room, else dropped.
  task automatic push_vec();
    logic [DATA_W-1:0] v;
    v = rand_vec();
    in_vld  = 1'b1;
    in_data = v;
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
    tick();
    in_vld = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                          input int rl, input int nr);
    base    = b;
    stride  = s;
    row_len = CNT_W'(rl);
    n_rows  = CNT_W'(nr);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < rl; c++)
        addr_q.push_back(ADDR_W'(longint'(b) + longint'(r) * longint'(s) + longint'(c)));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("state_run", 64'(state_dbg), 64'd1);
    check("ovf_cleared", 64'(ovf), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    int cyc;
    cyc = 0;
    while ((addr_q.size() != 0 || done_exp) && cyc < budget) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc >= budget) begin
      n_err++;
      $display("FAIL block_timeout: %0d writes still pending after %0d cycles", addr_q.size(), cyc);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check_data("rst_wr_data", wr_data, '0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_afull", 64'(in_afull), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
  endtask

  // Stimulus.
  initial begin
    int acc0;
    rst = 1'b1; start = 1'b0; base = '0; stride = '0; row_len = '0; n_rows = '0;
    in_vld = 1'b0; in_data = '0; wr_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_vals();

    // Basic block, vectors arrive after start.
    wr_rdy = 1'b1;
    do_start(21'h100, 21'h40, 3, 2);
    repeat (6) push_vec();
    wait_done(50);

    // Back-pressure mid-row.
    wr_rdy = 1'b0;
    repeat (8) push_vec();
    do_start(21'h200, 21'h10, 4, 2);
    wr_rdy = 1'b1;
    tick(); tick();
    wr_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_addr", 64'(wr_addr), 64'h202);
      check_data("stall_data", wr_data, exp_q[0]);
      check("stall_wr_en", 64'(wr_en), 64'd1);
    end
    wr_rdy = 1'b1;
    wait_done(50);
`ifdef PPU_OUT_WR_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'd5);
`endif

    // Early data: vectors pushed in IDLE with the buffer ready.
    repeat (4) push_vec();
    check("idle_no_busy", 64'(busy), 64'd0);
    do_start(21'h400, 21'h8, 4, 1);
    wait_done(50);

    // Overflow: 17 pushes into a 16-deep FIFO with no writes accepted.
    wr_rdy = 1'b0;
    do_start(21'h300, 21'h20, 16, 1);
    for (int k = 1; k <= 17; k++) begin
      push_vec();
      check("afull_level", 64'(in_afull),
            64'((DEPTH - exp_q.size()) <= AFULL_MARGIN));
    end
    check("ovf_set", 64'(ovf), 64'd1);
    wr_rdy = 1'b1;
    wait_done(100);
    check("ovf_sticky", 64'(ovf), 64'd1);

    // Address wrap-around.
    repeat (4) push_vec();
    do_start(21'h1FFFFE, 21'h1, 4, 1);
    wait_done(50);

    // Reset in the middle of a block.
    wr_rdy = 1'b0;
    repeat (6) push_vec();
    acc0 = n_acc;
    do_start(21'h500, 21'h40, 3, 2);
    wr_rdy = 1'b1;
    tick(); tick();
    check("writes_before_rst", 64'(n_acc - acc0), 64'd2);
    rst = 1'b1;
    wr_rdy = 1'b0;
    addr_q.delete();
    exp_q.delete();
    tick();
    rst = 1'b0;
    check_reset_vals();
    acc0 = n_acc;
    push_vec();
    wr_rdy = 1'b1;
    do_start(21'h55, 21'h3, 1, 1);
    wait_done(50);
    repeat (3) tick();
    check("one_write_after_rst", 64'(n_acc - acc0), 64'd1);

    // Randomized blocks with random arrivals and random back-pressure.
    for (int blk = 0; blk < 6; blk++) begin
      int rl, nr, total, pushed, cyc;
      rl = $urandom_range(1, 5);
      nr = $urandom_range(1, 3);
      total = rl * nr;
      pushed = 0;
      cyc = 0;
      wr_rdy = 1'b0;
      do_start(ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)),
               ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)), rl, nr);
      while ((addr_q.size() != 0 || done_exp) && cyc < 3000) begin
        wr_rdy = 1'($urandom_range(0, 1));
        if (pushed < total && exp_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
          push_vec();
          pushed++;
        end else begin
          tick();
        end
        cyc++;
      end
      n_cmp++;
      if (cyc >= 3000) begin
        n_err++;
        $display("FAIL rand_block_timeout: block %0d has %0d writes pending", blk, addr_q.size());
      end
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ppu_out_wr.md
Name: ppu_out_wr

Overview:
Back end of the PPU array. Captures the S*R-byte result vectors leaving the PPU array, buffers them in a small FIFO, and writes them to the output feature-map buffer as a 2-D block (rows x row_len) starting at a programmed base address. It also gives upstream issue logic an almost-full indication, because the PPU pipeline itself cannot be stalled.

Parameters:
- DEPTH, 16: FIFO depth in vectors; power of two, at least 4.
- AFULL_MARGIN, 8: free-entry threshold for in_afull; must be at least the PPU pipeline latency.
- ADDR_WIDTH, 21: width of the output buffer word address.
- CNT_WIDTH, 16: width of the row_len and n_rows fields.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle pulse; latches base, stride, row_len and n_rows.
- base, in, ADDR_WIDTH: first write address.
- stride, in, ADDR_WIDTH: address step between consecutive row starts.
- row_len, in, CNT_WIDTH: vectors per row; must be at least 1.
- n_rows, in, CNT_WIDTH: number of rows; must be at least 1.
- in_vld, in, 1: PPU out_tag; a result vector is present.
- in_data, in, `S*`R*8: PPU outs.
- in_afull, out, 1: asserted when free entries are at or below AFULL_MARGIN.
- wr_en, out, 1: write request valid.
- wr_addr, out, ADDR_WIDTH: write address.
- wr_data, out, `S*`R*8: write data.
- wr_rdy, in, 1: buffer accepts the write when wr_en && wr_rdy.
- busy, out, 1: high while the block is in RUN.
- done, out, 1: one-cycle pulse after the last write is accepted.
- ovf, out, 1: sticky flag; a vector arrived while the FIFO was full.

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, ovf=0, in_afull=0. FIFO is emptied, counters are zeroed, state is IDLE.
- FIFO push: on in_vld, a push always happens if the FIFO is not full. This applies in every state, so vectors arriving before start are kept.
- in_vld while full: the vector is dropped and ovf is set. ovf clears only on rst or the next start.
- Simultaneous push and pop on a full FIFO: the push is accepted, because the pop frees the slot in the same cycle.
- in_afull is registered and derived from the occupancy after the current cycle's push/pop.
- State IDLE: wr_en=0. On start, latch the operands, set row=0, col=0, row_base=base, set wr_addr=base, clear ovf, go to RUN.
- State RUN: wr_en is high whenever the FIFO is non-empty. wr_data is the FIFO head (first-word-fall-through, no extra latency).
- wr_addr/wr_data must stay stable while wr_en && !wr_rdy.
- On each accepted write, pop the FIFO, then:
  - If col < row_len-1: col++ and wr_addr++.
  - Otherwise, col=0, row++, row_base+=stride, wr_addr=row_base+stride.
  - If this was the last vector (row==n_rows-1 and col==row_len-1), go to DONE.
- State DONE: assert done for one cycle, drop busy, go to IDLE.
- Latency: a vector pushed into an empty FIFO during RUN appears on wr_en on the next cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH, with silent wrap-around.
- start during RUN or DONE is ignored.
- rst mid-operation aborts the transfer and discards the FIFO contents.
- Surplus vectors arriving after the last write stay in the FIFO for the next start.

Optional Feature:
PPU_OUT_WR_PERF_EN. When defined, the block adds two 32-bit outputs:
- stall_cnt: RUN cycles with wr_en && !wr_rdy.
- idle_cnt: RUN cycles with the FIFO empty.
Both counters clear on start and saturate at all-ones. When the macro is undefined, the ports and logic are absent and the rest of the behaviour is identical.

Decomposition:
- `S and `R come from incl.vh.
- The state encodings (IDLE=0, RUN=1, DONE=2) go in incl.vh as PPU_OUT_WR_* defines.
- One sub-module, ppu_out_fifo: a synchronous first-word-fall-through FIFO. It has parameters WIDTH and DEPTH, and ports push, pop, din, dout, empty, full and count.

Test Plan:
- Basic block: start with base=0x100, stride=0x40, row_len=3, n_rows=2, wr_rdy=1; push 6 vectors. Writes go to 0x100, 0x101, 0x102, 0x140, 0x141, 0x142 in order, data matches, done pulses once.
- Backpressure: hold wr_rdy=0 for 5 cycles mid-row. wr_addr/wr_data stay stable, there is no pop, the sequence resumes unchanged, and stall_cnt=5 when the macro is defined.
- Overflow: DEPTH=16, wr_rdy=0, push 17 vectors. ovf=1, in_afull was already asserted at 8 entries, and the first 16 are written intact once wr_rdy=1.
- Early data: push 4 vectors in IDLE, then start with row_len=4, n_rows=1. The 4 writes complete and done follows the 4th accepted write.
- Reset mid-run: assert rst after the 2nd of 6 writes. All outputs return to reset values, and a new start with a 1x1 block writes exactly one vector.
- Address wrap: base=2^21-2, row_len=4, n_rows=1. Addresses are 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001.
